// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for a host start pulse on the single-wire bus, then
// answers with the response preamble and a 40-bit humidity/temperature frame.
module dht11_responder #(
  parameter int US_CYCLES  = 1,
  parameter int T_START_US = 18000,
  parameter int T_WAIT_US  = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic       load,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done
);
  localparam int START_C = T_START_US * US_CYCLES;
  localparam int WAIT_C  = T_WAIT_US * US_CYCLES;
  localparam int RESP_C  = 80 * US_CYCLES;
  localparam int BLOW_C  = 50 * US_CYCLES;
  localparam int B0_C    = 26 * US_CYCLES;
  localparam int B1_C    = 70 * US_CYCLES;
  localparam int MAX_C   = (START_C > WAIT_C) ? ((START_C > RESP_C) ? START_C : RESP_C)
                                              : ((WAIT_C > RESP_C) ? WAIT_C : RESP_C);
  localparam int CNT_W   = $clog2(MAX_C + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [2:0] {
    IDLE, HOST_LOW, WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  function automatic logic [7:0] checksum(input logic [31:0] w);
    logic [9:0] sum;
    sum = {2'b00, w[31:24]} + {2'b00, w[23:16]} + {2'b00, w[15:8]} + {2'b00, w[7:0]};
    return sum[7:0];
  endfunction

  logic [1:0]  sync_q, sync_d;
  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] frame_q, frame_d;
  logic [31:0] shadow_q, shadow_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        line;

  assign line = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], dht_in};
    state_d   = state_q;
    cnt_d     = cnt_q + cnt_t'(1);
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    shadow_d  = load ? {hum_int, hum_dec, temp_int, temp_dec} : shadow_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!line) state_d = HOST_LOW;
      end
      HOST_LOW: begin
        // cnt_q is one less than the number of low cycles seen so far
        if (line) begin
          if (cnt_q >= cnt_t'(START_C - 1)) begin
            state_d = WAIT;
            busy_d  = 1'b1;
            frame_d = {shadow_q, checksum(shadow_q)};
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == cnt_t'(START_C)) begin
          cnt_d = cnt_q;
        end
      end
      WAIT: if (cnt_q == cnt_t'(WAIT_C - 1)) begin
        state_d = RESP_LOW;
        oe_d    = 1'b1;
      end
      RESP_LOW: if (cnt_q == cnt_t'(RESP_C - 1)) begin
        state_d = RESP_HIGH;
        oe_d    = 1'b0;
      end
      RESP_HIGH: if (cnt_q == cnt_t'(RESP_C - 1)) begin
        state_d   = BIT_LOW;
        oe_d      = 1'b1;
        bit_cnt_d = '0;
      end
      BIT_LOW: if (cnt_q == cnt_t'(BLOW_C - 1)) begin
        state_d = BIT_HIGH;
        oe_d    = 1'b0;
      end
      BIT_HIGH: begin
        // frame_q shifts left so the bit on the wire is always frame_q[39]
        if (cnt_q == (frame_q[39] ? cnt_t'(B1_C - 1) : cnt_t'(B0_C - 1))) begin
          frame_d = {frame_q[38:0], 1'b0};
          oe_d    = 1'b1;
          if (bit_cnt_q == 6'd39) begin
            state_d = END_LOW;
          end else begin
            state_d   = BIT_LOW;
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      END_LOW: if (cnt_q == cnt_t'(BLOW_C - 1)) begin
        state_d = IDLE;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      shadow_q  <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      shadow_q  <= shadow_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dht_oe     = oe_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder: measures every bus pulse the responder
// drives and decodes the frame, comparing against a byte-level model of the protocol.
module tb_dht11_responder;
  localparam int TS      = 300;
  localparam int TW      = 30;
  localparam int RUN_MAX = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, din1, din4, load;
  logic [7:0] hi, hd, ti, td;
  logic       oe1, busy1, done1, oe4, busy4, done4;

  dht11_responder #(.US_CYCLES(1), .T_START_US(TS), .T_WAIT_US(TW)) dut (
    .clk(clk), .rst_n(rst_n), .dht_in(din1), .dht_oe(oe1), .load(load),
    .hum_int(hi), .hum_dec(hd), .temp_int(ti), .temp_dec(td),
    .busy(busy1), .frame_done(done1));

  dht11_responder #(.US_CYCLES(4), .T_START_US(TS), .T_WAIT_US(TW)) dut4 (
    .clk(clk), .rst_n(rst_n), .dht_in(din4), .dht_oe(oe4), .load(load),
    .hum_int(hi), .hum_dec(hd), .temp_int(ti), .temp_dec(td),
    .busy(busy4), .frame_done(done4));

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  chk;
  } vec_t;

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] sh_w;
  int          hook_load_bit = -1;
  int          hook_rst_bit  = -1;
  logic [31:0] hook_w;

  task automatic check(input string name, input longint got, input longint exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Expected frame: four bytes followed by their sum modulo 256
  function automatic logic [39:0] model_frame(input logic [31:0] w);
    int s;
    s = int'(w[31:24]) + int'(w[23:16]) + int'(w[15:8]) + int'(w[7:0]);
    return {w, 8'(s % 256)};
  endfunction

  function automatic logic oe_of(input bit s4);   return s4 ? oe4 : oe1;     endfunction
  function automatic logic busy_of(input bit s4); return s4 ? busy4 : busy1; endfunction
  function automatic logic done_of(input bit s4); return s4 ? done4 : done1; endfunction

  task automatic step();
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] w);
    {hi, hd, ti, td} = w;
    load = 1'b1;
    sh_w = w;
  endtask

  task automatic host_low(input bit s4, input int n);
    if (s4) din4 = 1'b0; else din1 = 1'b0;
    repeat (n) step();
    if (s4) din4 = 1'b1; else din1 = 1'b1;
  endtask

  task automatic run_len(input bit s4, input logic lvl, output int n);
    n = 0;
    while (oe_of(s4) == lvl && n < RUN_MAX) begin
      n++;
      step();
    end
  endtask

  task automatic watch_idle(input string tag, input int cyc);
    int act;
    act = 0;
    repeat (cyc) begin
      step();
      if (oe1 || busy1 || done1) act++;
    end
    check(tag, act, 0);
  endtask

  // Called right after the host releases the line; measures the whole response.
  task automatic capture(input bit s4, input logic [39:0] exp, input string tag);
    int u, n, bad_lo, bad_hi;
    logic [39:0] got;
    u = s4 ? 4 : 1;
    step();
    run_len(s4, 1'b0, n);
    check({tag, "_gap"}, n, TW * u + 2);
    check({tag, "_busy"}, busy_of(s4), 1);
    run_len(s4, 1'b1, n);
    check({tag, "_resp_low"}, n, 80 * u);
    run_len(s4, 1'b0, n);
    check({tag, "_resp_high"}, n, 80 * u);
    bad_lo = 0;
    bad_hi = 0;
    got    = '0;
    for (int i = 0; i < 40; i++) begin
      if (i == hook_load_bit) do_load(hook_w);
      run_len(s4, 1'b1, n);
      if (n != 50 * u) bad_lo++;
      if (i == hook_rst_bit) begin
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_oe"}, oe_of(s4), 0);
        check({tag, "_rst_busy"}, busy_of(s4), 0);
        return;
      end
      run_len(s4, 1'b0, n);
      if (n >= RUN_MAX) begin
        check({tag, "_stuck"}, n, 0);
        return;
      end
      got = {got[38:0], (n > 48 * u)};
      if (n != (exp[39-i] ? 70 : 26) * u) bad_hi++;
    end
    check({tag, "_bit_low_widths"}, bad_lo, 0);
    check({tag, "_bit_high_widths"}, bad_hi, 0);
    check({tag, "_data"}, got, exp);
    run_len(s4, 1'b1, n);
    check({tag, "_end_low"}, n, 50 * u);
    check({tag, "_done"}, done_of(s4), 1);
    check({tag, "_busy_clr"}, busy_of(s4), 0);
    step();
    check({tag, "_done_pulse"}, done_of(s4), 0);
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[4];
    logic [31:0] rw;
    logic [39:0] ef;
    int          n;

    tbl[0] = '{data: 32'h37001905, chk: 8'h55};
    tbl[1] = '{data: 32'hFFFF0100, chk: 8'hFF};
    tbl[2] = '{data: 32'h11223344, chk: 8'hAA};
    tbl[3] = '{data: 32'h12345678, chk: 8'h14};

    rst_n = 1'b0; din1 = 1'b1; din4 = 1'b1; load = 1'b0;
    hi = '0; hd = '0; ti = '0; td = '0; sh_w = '0;
    repeat (3) @(negedge clk);
    check("reset_oe", oe1, 0);
    check("reset_busy", busy1, 0);
    check("reset_done", done1, 0);
    check("reset_oe4", oe4, 0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 4; k++) begin
      do_load(tbl[k].data);
      step();
      host_low(1'b0, TS);
      capture(1'b0, {tbl[k].data, tbl[k].chk}, $sformatf("vec%0d", k));
    end

    // Short host lows must never start a frame
    host_low(1'b0, TS * 10 / 18);
    watch_idle("short_low", TS + 50);
    host_low(1'b0, TS - 1);
    watch_idle("low_ts_minus_1", TS + 50);
    host_low(1'b0, $urandom_range(TS - 2, 1));
    watch_idle("low_random_short", TS + 50);

    // Exactly the threshold qualifies
    host_low(1'b0, TS);
    capture(1'b0, model_frame(sh_w), "low_exact");

    // Long low plus a load in the middle of bit 10
    do_load(32'h37001905);
    step();
    hook_w = 32'h11223344;
    hook_load_bit = 10;
    host_low(1'b0, 2 * TS + 7);
    capture(1'b0, 40'h3700190555, "inflight");
    hook_load_bit = -1;
    host_low(1'b0, TS);
    capture(1'b0, 40'h11223344AA, "after_load");

    // Host pulling low mid-frame is ignored
    rw = $urandom;
    do_load(rw);
    step();
    host_low(1'b0, TS);
    ef = model_frame(sh_w);
    fork
      capture(1'b0, ef, "host_glitch");
      begin
        repeat (400) @(negedge clk);
        din1 = 1'b0;
        repeat (TS + 10) @(negedge clk);
        din1 = 1'b1;
      end
    join
    watch_idle("no_restart", 200);

    rw = $urandom;
    do_load(rw);
    step();
    host_low(1'b0, TS);
    capture(1'b0, model_frame(sh_w), "random");

    // Reset while the response preamble is driving the line low
    host_low(1'b0, TS);
    n = 0;
    while (!oe1 && n < 200) begin
      n++;
      step();
    end
    check("rstA_reach_low", oe1, 1);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("rstA_oe", oe1, 0);
    check("rstA_busy", busy1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sh_w  = '0;

    // Reset during bit 20, then a fresh frame reports the cleared shadow bytes
    do_load(32'hA5C3_5A3C);
    step();
    hook_rst_bit = 20;
    host_low(1'b0, TS);
    capture(1'b0, model_frame(sh_w), "rstB");
    hook_rst_bit = -1;
    @(negedge clk);
    rst_n = 1'b1;
    sh_w  = '0;
    watch_idle("post_reset_idle", 50);
    host_low(1'b0, TS);
    capture(1'b0, model_frame(sh_w), "post_reset");

    // Scaled timing instance
    do_load(32'h37001905);
    step();
    host_low(1'b1, 4 * TS);
    capture(1'b1, 40'h3700190555, "us4");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
